// File: rtl/shifter_arbiter_if.sv
// Handshake bundle for the shared shifter: two request ports and one result port.
// The arbiter is the slave; requesters and the result consumer form the master side.
interface shifter_arbiter_if #(
    parameter int TAG_W = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [31:0]      req0_rm;
    logic [11:0]      req0_i;
    logic [1:0]       req0_am;
    logic [TAG_W-1:0] req0_tag;

    logic             req1_valid;
    logic             req1_ready;
    logic [31:0]      req1_rm;
    logic [11:0]      req1_i;
    logic [1:0]       req1_am;
    logic [TAG_W-1:0] req1_tag;

    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_data;
    logic             res_src;
    logic [TAG_W-1:0] res_tag;

    modport slave (
        input  req0_valid, req0_rm, req0_i, req0_am, req0_tag,
        output req0_ready,
        input  req1_valid, req1_rm, req1_i, req1_am, req1_tag,
        output req1_ready,
        output res_valid, res_data, res_src, res_tag,
        input  res_ready
    );

    modport master (
        output req0_valid, req0_rm, req0_i, req0_am, req0_tag,
        input  req0_ready,
        output req1_valid, req1_rm, req1_i, req1_am, req1_tag,
        input  req1_ready,
        input  res_valid, res_data, res_src, res_tag,
        output res_ready
    );
endinterface

// File: rtl/shifter_arbiter.sv
// Round-robin arbiter sharing one combinational operand-2 shifter between two
// requesters; result is registered and held on a valid/ready port.
module shifter (
    input  logic [31:0] rm,
    input  logic [11:0] i,
    input  logic [1:0]  am,
    output logic [31:0] n_shift
);
    logic [5:0]  imm_rot;
    logic [5:0]  sh_amt;
    logic [31:0] imm8;

    always_comb begin
        imm_rot = {1'b0, i[11:8], 1'b0};
        sh_amt  = {1'b0, i[11:7]};
        imm8    = {24'd0, i[7:0]};
        n_shift = 32'd0;
        case (am)
            // Shifting by 32 yields zero, so a zero rotate leaves the value intact.
            2'b00: n_shift = (imm8 >> imm_rot) | (imm8 << (6'd32 - imm_rot));
            2'b01: n_shift = rm;
            2'b10: n_shift = {20'd0, i};
            default: begin
                case (i[6:5])
                    2'b00:   n_shift = rm << sh_amt;
                    2'b01:   n_shift = rm >> sh_amt;
                    2'b10:   n_shift = 32'($signed(rm) >>> sh_amt);
                    default: n_shift = (rm >> sh_amt) | (rm << (6'd32 - sh_amt));
                endcase
            end
        endcase
    end
endmodule

module shifter_arbiter #(
    parameter int TAG_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    shifter_arbiter_if.slave    bus,
    output logic                busy,
    output logic [7:0]          conflict_cnt
);
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t           state_reg, state_next;
    logic             last_grant_reg;
    logic [7:0]       conflict_cnt_reg;
    logic [31:0]      op_rm_reg;
    logic [11:0]      op_i_reg;
    logic [1:0]       op_am_reg;
    logic [TAG_W-1:0] op_tag_reg;
    logic             op_src_reg;
    logic             res_valid_reg;
    logic [31:0]      res_data_reg;
    logic             res_src_reg;
    logic [TAG_W-1:0] res_tag_reg;

    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic        accept_slot;
    logic        both_valid;
    logic        winner;
    logic        accept;
    logic [31:0] n_shift;

    assign req_valid   = {bus.req1_valid, bus.req0_valid};
    assign accept_slot = (state_reg == IDLE) || (state_reg == HOLD && bus.res_ready);
    assign both_valid  = &req_valid;
    // On a tie the requester that did not win last time goes first.
    assign winner      = both_valid ? ~last_grant_reg : req_valid[1];
    assign accept      = accept_slot && (|req_valid) && !reset;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = accept_slot && !reset && req_valid[gi] && (winner == 1'(gi));
        end
    endgenerate

    assign bus.req0_ready = req_ready[0];
    assign bus.req1_ready = req_ready[1];

    shifter u_shifter (
        .rm      (op_rm_reg),
        .i       (op_i_reg),
        .am      (op_am_reg),
        .n_shift (n_shift)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = SHIFT;
            SHIFT:   state_next = HOLD;
            HOLD:    if (bus.res_ready) state_next = accept ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            res_valid_reg    <= 1'b0;
            res_data_reg     <= 32'd0;
            res_src_reg      <= 1'b0;
            res_tag_reg      <= '0;
            last_grant_reg   <= 1'b1;
            conflict_cnt_reg <= 8'd0;
        end else begin
            if (accept) begin
                op_rm_reg      <= winner ? bus.req1_rm  : bus.req0_rm;
                op_i_reg       <= winner ? bus.req1_i   : bus.req0_i;
                op_am_reg      <= winner ? bus.req1_am  : bus.req0_am;
                op_tag_reg     <= winner ? bus.req1_tag : bus.req0_tag;
                op_src_reg     <= winner;
                last_grant_reg <= winner;
                if (both_valid && conflict_cnt_reg != 8'hFF) begin
                    conflict_cnt_reg <= conflict_cnt_reg + 8'd1;
                end
            end
            if (state_reg == SHIFT) begin
                res_valid_reg <= 1'b1;
                res_data_reg  <= n_shift;
                res_src_reg   <= op_src_reg;
                res_tag_reg   <= op_tag_reg;
            end else if (state_reg == HOLD && bus.res_ready) begin
                res_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.res_valid = res_valid_reg;
    assign bus.res_data  = res_data_reg;
    assign bus.res_src   = res_src_reg;
    assign bus.res_tag   = res_tag_reg;
    assign busy          = (state_reg != IDLE);
    assign conflict_cnt  = conflict_cnt_reg;
endmodule

// File: tb/tb_shifter_arbiter.sv
// Directed bench for shifter_arbiter: transaction-level model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_shifter_arbiter;
    localparam int TAG_W = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       busy;
    logic [7:0] conflict_cnt;

    shifter_arbiter_if #(.TAG_W(TAG_W)) bus();

    shifter_arbiter #(.TAG_W(TAG_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .busy         (busy),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      data;
        logic             src;
        logic [TAG_W-1:0] tag;
    } res_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] shift_fn(input logic [31:0] rm, input logic [11:0] i,
                                             input logic [1:0] am);
        logic [63:0] dbl;
        logic [31:0] imm8;
        int amt;
        imm8 = {24'd0, i[7:0]};
        case (am)
            2'b00: begin
                amt = 2 * int'(i[11:8]);
                dbl = {imm8, imm8} >> amt;
                return dbl[31:0];
            end
            2'b01: return rm;
            2'b10: return {20'd0, i};
            default: begin
                amt = int'(i[11:7]);
                case (i[6:5])
                    2'b00: return rm << amt;
                    2'b01: return rm >> amt;
                    2'b10: return 32'($signed(rm) >>> amt);
                    default: begin
                        dbl = {rm, rm} >> amt;
                        return dbl[31:0];
                    end
                endcase
            end
        endcase
    endfunction

    // Model: phase 0 idle, 1 computing, 2 result held.
    res_t exp_q[$];
    res_t m_res;
    int   m_phase = 0;
    logic m_last = 1'b1;
    int   m_cnt = 0;
    logic m_rv = 1'b0;
    bit   seen_reset = 1'b0;

    always @(posedge clk) if (reset) seen_reset <= 1'b1;

    always @(negedge clk) begin : model_cmp
        logic slot, both, win, acc, v0, v1;
        res_t nr;
        if (seen_reset) begin
            v0 = bus.req0_valid;
            v1 = bus.req1_valid;
            check("res_valid", bus.res_valid, m_rv);
            check("busy", busy, m_phase != 0);
            check("conflict_cnt", conflict_cnt, m_cnt);
            if (m_rv) begin
                check("res_data", bus.res_data, m_res.data);
                check("res_src", bus.res_src, m_res.src);
                check("res_tag", bus.res_tag, m_res.tag);
            end
            if (reset) begin
                m_phase = 0; m_last = 1'b1; m_cnt = 0; m_rv = 1'b0;
                exp_q.delete();
            end else begin
                slot = (m_phase == 0) || (m_phase == 2 && bus.res_ready);
                both = v0 && v1;
                win  = both ? !m_last : v1;
                acc  = slot && (v0 || v1);
                if (v0) check("req0_ready", bus.req0_ready, slot && !win);
                if (v1) check("req1_ready", bus.req1_ready, slot && win);
                if (m_phase == 1) begin
                    m_res = exp_q.pop_front();
                    m_rv = 1'b1;
                    m_phase = 2;
                end else if (m_phase == 2 && bus.res_ready) begin
                    m_rv = 1'b0;
                    m_phase = 0;
                end
                if (acc) begin
                    nr.data = win ? shift_fn(bus.req1_rm, bus.req1_i, bus.req1_am)
                                  : shift_fn(bus.req0_rm, bus.req0_i, bus.req0_am);
                    nr.src  = win;
                    nr.tag  = win ? bus.req1_tag : bus.req0_tag;
                    exp_q.push_back(nr);
                    m_last = win;
                    if (both && m_cnt < 255) m_cnt++;
                    m_phase = 1;
                end
            end
        end
    end

    res_t res_log[$];

    always @(negedge clk) begin : capture
        res_t r;
        if (!reset && bus.res_valid && bus.res_ready) begin
            r.data = bus.res_data;
            r.src  = bus.res_src;
            r.tag  = bus.res_tag;
            res_log.push_back(r);
            $display("txn src=%0d tag=%0d data=0x%08h", r.src, r.tag, r.data);
        end
    end

    task automatic set_req(input int n, input logic v, input logic [31:0] rm,
                           input logic [11:0] i, input logic [1:0] am, input logic [3:0] tag);
        if (n == 0) begin
            bus.req0_valid = v; bus.req0_rm = rm; bus.req0_i = i;
            bus.req0_am = am; bus.req0_tag = tag;
        end else begin
            bus.req1_valid = v; bus.req1_rm = rm; bus.req1_i = i;
            bus.req1_am = am; bus.req1_tag = tag;
        end
    endtask

    task automatic send(input int n, input logic [31:0] rm, input logic [11:0] i,
                        input logic [1:0] am, input logic [3:0] tag, output int waited);
        bit got = 1'b0;
        waited = 0;
        set_req(n, 1'b1, rm, i, am, tag);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            got = (n == 0) ? bus.req0_ready : bus.req1_ready;
            @(posedge clk); #1;
            if (got) break;
            waited++;
        end
        if (n == 0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
        check("send_accepted", got, 1'b1);
    endtask

    task automatic wait_results(input int n);
        for (int c = 0; c < 100 && res_log.size() < n; c++) begin
            @(posedge clk); #1;
        end
        check("result_count", res_log.size(), n);
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int w;
        int grants[$];
        bus.res_ready = 1'b1;
        set_req(0, 1'b0, 32'd0, 12'd0, 2'd0, 4'd0);
        set_req(1, 1'b0, 32'd0, 12'd0, 2'd0, 4'd0);

        check("pin_lsl", shift_fn(32'h0431FFEA, 12'h104, 2'b11), 32'h10C7FFA8);
        check("pin_lsr", shift_fn(32'h0431FFEA, 12'h124, 2'b11), 32'h010C7FFA);
        check("pin_rot_imm", shift_fn(32'd0, 12'h40C, 2'b00), 32'h0C000000);
        check("pin_asr", shift_fn(32'h80000000, 12'h240, 2'b11), 32'hF8000000);

        idle(2);
        reset = 1'b0;
        @(negedge clk);
        check("rst_res_valid", bus.res_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_cnt", conflict_cnt, 8'd0);
        check("rst_res_data", bus.res_data, 32'd0);
        @(posedge clk); #1;

        // Single op with two-cycle latency.
        send(0, 32'h0431FFEA, 12'h000, 2'b01, 4'd3, w);
        check("t1_ready_same_cycle", w, 0);
        @(negedge clk);
        check("t1_not_yet_valid", bus.res_valid, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_valid", bus.res_valid, 1'b1);
        @(posedge clk); #1;
        wait_results(1);
        check("t1_data", res_log[0].data, 32'h0431FFEA);
        check("t1_src", res_log[0].src, 1'b0);
        check("t1_tag", res_log[0].tag, 4'd3);
        res_log.delete();

        send(1, 32'd0, 12'h40C, 2'b10, 4'd1, w);
        send(1, 32'd0, 12'h40C, 2'b00, 4'd2, w);
        send(0, 32'h80000000, 12'h240, 2'b11, 4'd4, w);
        send(1, 32'h0000000F, 12'h260, 2'b11, 4'd5, w);
        wait_results(4);
        check("t2_zext", res_log[0].data, 32'h0000040C);
        check("t2_src", res_log[0].src, 1'b1);
        check("t2_rot_imm", res_log[1].data, 32'h0C000000);
        check("t2_asr", res_log[2].data, 32'hF8000000);
        check("t2_ror", res_log[3].data, 32'hF0000000);
        res_log.delete();
        idle(2);

        // Conflict: both held valid, grants must alternate starting with 0.
        set_req(0, 1'b1, 32'h0431FFEA, 12'h104, 2'b11, 4'd1);
        set_req(1, 1'b1, 32'h0431FFEA, 12'h124, 2'b11, 4'd2);
        for (int c = 0; c < 40 && grants.size() < 4; c++) begin
            @(negedge clk);
            if (bus.req0_ready) grants.push_back(0);
            else if (bus.req1_ready) grants.push_back(1);
            @(posedge clk); #1;
            if (grants.size() == 1) check("cf_cnt_first", conflict_cnt, 8'd1);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        check("cf_grant_count", grants.size(), 4);
        for (int k = 0; k < 4 && k < grants.size(); k++) check("cf_grant_order", grants[k], k % 2);
        wait_results(4);
        check("cf_res0", res_log[0].data, 32'h10C7FFA8);
        check("cf_res1", res_log[1].data, 32'h010C7FFA);
        check("cf_src1", res_log[1].src, 1'b1);
        check("cf_cnt", conflict_cnt, 8'd4);
        res_log.delete();
        idle(2);

        // Backpressure: result held for 5 cycles, then consumed with a same-cycle accept.
        bus.res_ready = 1'b0;
        send(0, 32'hDEADBEEF, 12'h000, 2'b01, 4'd5, w);
        @(posedge clk); #1;
        set_req(0, 1'b1, 32'h12345678, 12'h000, 2'b01, 4'd6);
        set_req(1, 1'b1, 32'h0000FFFF, 12'h000, 2'b01, 4'd7);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_data", bus.res_data, 32'hDEADBEEF);
            check("bp_tag", bus.res_tag, 4'd5);
            check("bp_r0", bus.req0_ready, 1'b0);
            check("bp_r1", bus.req1_ready, 1'b0);
            check("bp_busy", busy, 1'b1);
            @(posedge clk); #1;
        end
        bus.req1_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        check("bp_accept_same_cycle", bus.req0_ready, 1'b1);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        wait_results(2);
        check("bp_first", res_log[0].data, 32'hDEADBEEF);
        check("bp_second", res_log[1].data, 32'h12345678);
        check("bp_second_tag", res_log[1].tag, 4'd6);
        res_log.delete();
        idle(2);

        // Reset while the op is in SHIFT: it must vanish.
        send(1, 32'd0, 12'h40C, 2'b10, 4'd9, w);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("mr_res_valid", bus.res_valid, 1'b0);
        check("mr_busy", busy, 1'b0);
        check("mr_cnt", conflict_cnt, 8'd0);
        idle(6);
        check("mr_no_result", res_log.size(), 0);

        // Saturation: 300 conflicting accepts.
        grants.delete();
        set_req(0, 1'b1, 32'h1, 12'h000, 2'b01, 4'd0);
        set_req(1, 1'b1, 32'h2, 12'h000, 2'b01, 4'd1);
        for (int c = 0; c < 2000 && grants.size() < 300; c++) begin
            @(negedge clk);
            if (bus.req0_ready || bus.req1_ready) grants.push_back(1);
            @(posedge clk); #1;
            if (grants.size() == 255) check("sat_at_255", conflict_cnt, 8'd255);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        check("sat_accepts", grants.size(), 300);
        idle(4);
        check("sat_cnt", conflict_cnt, 8'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
